// File: rtl/ksa_fsm.sv
// RC4 key-scheduling controller: initialises the shared S RAM to the identity
// and then runs the keyed swap loop, handing off to the decrypt stage via done.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// INIT_WR  | write S[i] = i for i = 0..255
// RD_I     | present address i
// WAIT_I   | RD_LAT cycles for S[i] to arrive on q
// CALC_J   | latch S[i], advance j by S[i] + key byte
// RD_J     | present address j
// WAIT_J   | RD_LAT cycles for S[j] to arrive on q
// WR_J     | latch S[j], write S[j] <= S[i]
// WR_I     | write S[i] <= S[j], advance i or finish
// DONE     | S is a keyed permutation; hold until start is seen low
module ksa_fsm #(
    parameter int RD_LAT    = 2,
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             q,
    output logic [7:0]             address,
    output logic [7:0]             data,
    output logic                   wren,
    output logic                   busy,
    output logic                   done
);

    localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_WR, S_RD_I, S_WAIT_I, S_CALC_J,
        S_RD_J, S_WAIT_J, S_WR_J, S_WR_I, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [KW-1:0] kidx_q, kidx_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [7:0]    address_q, address_d, data_q, data_d;
    logic          wren_q, wren_d, busy_q, busy_d, done_q, done_d;
    logic [7:0]    key_byte;

    // Byte 0 of the key occupies the most significant byte lane.
    always_comb begin
        key_byte = secret_key[8*KEY_BYTES-1 -: 8];
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx_q == KW'(k)) key_byte = secret_key[8*(KEY_BYTES-k)-1 -: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        kidx_d    = kidx_q;
        wait_d    = wait_q;
        address_d = address_q;
        data_d    = data_q;
        wren_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT_WR;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    kidx_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_INIT_WR: begin
                address_d = i_q;
                data_d    = i_q;
                wren_d    = 1'b1;
                i_d       = i_q + 8'd1;
                if (i_q == 8'd255) state_d = S_RD_I;
            end
            S_RD_I: begin
                address_d = i_q;
                wait_d    = WW'(RD_LAT - 1);
                state_d   = S_WAIT_I;
            end
            S_WAIT_I: begin
                if (wait_q == '0) state_d = S_CALC_J;
                else              wait_d  = wait_q - WW'(1);
            end
            S_CALC_J: begin
                si_d    = q;
                j_d     = j_q + q + key_byte;
                state_d = S_RD_J;
            end
            S_RD_J: begin
                address_d = j_q;
                wait_d    = WW'(RD_LAT - 1);
                state_d   = S_WAIT_J;
            end
            S_WAIT_J: begin
                if (wait_q == '0) state_d = S_WR_J;
                else              wait_d  = wait_q - WW'(1);
            end
            S_WR_J: begin
                sj_d      = q;
                address_d = j_q;
                data_d    = si_q;
                wren_d    = 1'b1;
                state_d   = S_WR_I;
            end
            S_WR_I: begin
                address_d = i_q;
                data_d    = sj_q;
                wren_d    = 1'b1;
                i_d       = i_q + 8'd1;
                kidx_d    = (kidx_q == KW'(KEY_BYTES - 1)) ? '0 : kidx_q + KW'(1);
                state_d   = (i_q == 8'd255) ? S_DONE : S_RD_I;
            end
            S_DONE: begin
                address_d = 8'd0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                // done must be visible at least one cycle before start low releases it
                if (done_q && !start) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            si_q      <= 8'd0;
            sj_q      <= 8'd0;
            kidx_q    <= '0;
            wait_q    <= '0;
            address_q <= 8'd0;
            data_q    <= 8'd0;
            wren_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            kidx_q    <= kidx_d;
            wait_q    <= wait_d;
            address_q <= address_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign address = address_q;
    assign data    = data_q;
    assign wren    = wren_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_ksa_fsm.sv
// Bench for ksa_fsm: RAM models with read latency, an RC4 KSA reference model
// and a scoreboard queue popped by monitors when done rises.
module tb_ksa_fsm;

    localparam int LAT2 = 1 + 256 + 256 * (5 + 2 * 2);
    localparam int LAT3 = 1 + 256 + 256 * (5 + 2 * 3);

    typedef struct packed {
        logic [2047:0] s;
        logic [31:0]   exp_cyc;
        logic [7:0]    w0a, w0d, w1a, w1d;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, start3;
    logic [23:0] key;
    logic [7:0]  q2, q3, addr2, addr3, data2, data3;
    logic        wren2, wren3, busy2, busy3, done2, done3;

    always #5 clk = ~clk;

    ksa_fsm #(.RD_LAT(2), .KEY_BYTES(3)) dut (
        .clk(clk), .reset(reset), .start(start), .secret_key(key), .q(q2),
        .address(addr2), .data(data2), .wren(wren2), .busy(busy2), .done(done2));

    ksa_fsm #(.RD_LAT(3), .KEY_BYTES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .secret_key(key), .q(q3),
        .address(addr3), .data(data3), .wren(wren3), .busy(busy3), .done(done3));

    logic [7:0] mem2 [256];
    logic [7:0] mem3 [256];
    logic [7:0] pipe2 [2];
    logic [7:0] pipe3 [3];

    always @(posedge clk) begin
        if (wren2) mem2[addr2] <= data2;
        pipe2[0] <= mem2[addr2];
        pipe2[1] <= pipe2[0];
        if (wren3) mem3[addr3] <= data3;
        pipe3[0] <= mem3[addr3];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign q2 = pipe2[1];
    assign q3 = pipe3[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t exp3_q[$];
    int   wcnt = 0;
    int   bus_viol = 0;
    int   runs_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2047:0] ksa_model(input logic [23:0] k);
        logic [7:0]    s [256];
        logic [7:0]    kb [3];
        logic [7:0]    t;
        logic [2047:0] r;
        int            j;
        kb[0] = k[23:16];
        kb[1] = k[15:8];
        kb[2] = k[7:0];
        for (int n = 0; n < 256; n++) s[n] = n[7:0];
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + int'(s[n]) + int'(kb[n % 3])) % 256;
            t = s[n];
            s[n] = s[j];
            s[j] = t;
        end
        for (int n = 0; n < 256; n++) r[8*n +: 8] = s[n];
        return r;
    endfunction

    // Main monitor: write-stream checks and scoreboard pop on done rising.
    initial begin
        logic busy_p, done_p, wren_p;
        logic init_bad;
        logic [7:0] fw0a, fw0d, fw1a, fw1d;
        exp_t e;
        int mism, bad;
        int seen [256];
        busy_p = 0; done_p = 0; wren_p = 0; init_bad = 0;
        fw0a = 0; fw0d = 0; fw1a = 0; fw1d = 0;
        forever begin
            @(negedge clk);
            if (wren2 && !busy2) bus_viol++;
            if (busy2 && !busy_p) begin
                wcnt = 0;
                init_bad = 0;
            end
            if (wren2) begin
                if (wcnt < 256) begin
                    if (addr2 != wcnt[7:0] || data2 != wcnt[7:0]) init_bad = 1;
                    if (wcnt > 0 && !wren_p) init_bad = 1;
                end else if (wcnt == 256) begin
                    fw0a = addr2; fw0d = data2;
                end else if (wcnt == 257) begin
                    fw1a = addr2; fw1d = data2;
                end
                wcnt++;
            end
            if (done2 && !done_p) begin
                chk("sb_has_entry", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    runs_done++;
                    chk("done_cycle", 64'(cyc), 64'(e.exp_cyc));
                    mism = 0;
                    for (int n = 0; n < 256; n++) if (mem2[n] !== e.s[8*n +: 8]) mism++;
                    chk("ram_vs_model", 64'(mism), 0);
                    for (int v = 0; v < 256; v++) seen[v] = 0;
                    for (int n = 0; n < 256; n++) seen[mem2[n]]++;
                    bad = 0;
                    for (int v = 0; v < 256; v++) if (seen[v] != 1) bad++;
                    chk("permutation", 64'(bad), 0);
                    chk("write_count", 64'(wcnt), 768);
                    chk("init_sequence", 64'(init_bad), 0);
                    chk("ksa_w0_addr", 64'(fw0a), 64'(e.w0a));
                    chk("ksa_w0_data", 64'(fw0d), 64'(e.w0d));
                    chk("ksa_w1_addr", 64'(fw1a), 64'(e.w1a));
                    chk("ksa_w1_data", 64'(fw1d), 64'(e.w1d));
                end
            end
            busy_p = busy2;
            done_p = done2;
            wren_p = wren2;
        end
    end

    // RD_LAT=3 instance monitor.
    initial begin
        logic done_p;
        exp_t e;
        int mism;
        done_p = 0;
        forever begin
            @(negedge clk);
            if (done3 && !done_p) begin
                chk("sb3_has_entry", 64'(exp3_q.size() != 0), 1);
                if (exp3_q.size() != 0) begin
                    e = exp3_q.pop_front();
                    chk("done_cycle_lat3", 64'(cyc), 64'(e.exp_cyc));
                    mism = 0;
                    for (int n = 0; n < 256; n++) if (mem3[n] !== e.s[8*n +: 8]) mism++;
                    chk("ram_vs_model_lat3", 64'(mism), 0);
                end
            end
            done_p = done3;
        end
    end

    // Called at a negedge with the DUT(s) idle; returns at the negedge after acceptance.
    task automatic issue_start(input logic [23:0] k, input bit use3, input bit expect_done);
        exp_t e;
        key = k;
        e.s = ksa_model(k);
        e.w0a = k[23:16];
        e.w0d = 8'd0;
        e.w1a = 8'd0;
        e.w1d = k[23:16];
        e.exp_cyc = 32'(cyc + 1 + LAT2);
        if (expect_done) exp_q.push_back(e);
        if (use3) begin
            e.exp_cyc = 32'(cyc + 1 + LAT3);
            exp3_q.push_back(e);
            start3 = 1'b1;
        end
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done2();
        int n;
        n = 0;
        while (!done2 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", 64'(done2), 1);
    endtask

    task automatic release_done();
        repeat (2) @(negedge clk);
        chk("done_released", 64'(done2), 0);
    endtask

    initial begin
        int c0, n, hold_bad, full_runs;
        reset = 1'b0; start = 1'b0; start3 = 1'b0; key = 24'h0;
        full_runs = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_address", 64'(addr2), 0);
        chk("rst_data", 64'(data2), 0);
        chk("rst_wren", 64'(wren2), 0);
        chk("rst_busy", 64'(busy2), 0);
        chk("rst_done", 64'(done2), 0);
        reset = 1'b1;
        @(negedge clk);

        // Zero key (also forces i==j at iteration 0), then a fixed key.
        issue_start(24'h000000, 0, 1);
        chk("busy_after_accept", 64'(busy2), 1);
        wait_done2(); full_runs++;
        chk("busy_at_done", 64'(busy2), 0);
        release_done();
        issue_start(24'h000249, 0, 1);
        wait_done2(); full_runs++;
        release_done();

        // Reset during init at i=100.
        issue_start(24'($urandom), 0, 0);
        n = 0;
        while (!(wren2 && addr2 == 8'd100) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("reached_init_100", 64'(wren2 && addr2 == 8'd100), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_wren", 64'(wren2), 0);
        chk("rst_mid_busy", 64'(busy2), 0);
        chk("rst_mid_done", 64'(done2), 0);
        chk("rst_mid_address", 64'(addr2), 0);
        reset = 1'b1;
        @(negedge clk);
        issue_start(24'($urandom), 0, 1);
        wait_done2(); full_runs++;
        release_done();

        // Reset while in WR_J of KSA iteration 40.
        issue_start(24'($urandom), 0, 0);
        c0 = cyc;
        while (cyc < c0 + 256 + 40 * 9 + 7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_wrj_wren", 64'(wren2), 0);
        chk("rst_wrj_busy", 64'(busy2), 0);
        chk("rst_wrj_done", 64'(done2), 0);
        chk("rst_wrj_address", 64'(addr2), 0);
        reset = 1'b1;
        @(negedge clk);
        issue_start(24'($urandom), 0, 1);
        wait_done2(); full_runs++;
        release_done();

        // Start pulse while busy, start held high into DONE.
        issue_start(24'($urandom), 0, 1);
        c0 = cyc;
        while (cyc < c0 + 500) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 2550) @(negedge clk);
        start = 1'b1;
        wait_done2(); full_runs++;
        hold_bad = 0;
        for (int h = 0; h < 20; h++) begin
            @(negedge clk);
            if (!done2 || busy2 || wren2) hold_bad++;
        end
        chk("hold_in_done", 64'(hold_bad), 0);
        chk("hold_no_extra_writes", 64'(wcnt), 768);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("done_drop_on_start_low", 64'(done2), 0);
        chk("idle_busy_low", 64'(busy2), 0);
        issue_start(24'($urandom), 0, 1);
        wait_done2(); full_runs++;
        release_done();

        // Random keys; the first also runs the RD_LAT=3 instance.
        for (int r = 0; r < 3; r++) begin
            issue_start(24'($urandom), r == 0, 1);
            wait_done2(); full_runs++;
            if (r == 0) begin
                n = 0;
                while (!done3 && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                chk("done3_reached", 64'(done3), 1);
            end
            release_done();
        end

        repeat (4) @(negedge clk);
        chk("bus_rule", 64'(bus_viol), 0);
        chk("runs_completed", 64'(runs_done), 64'(full_runs));
        chk("sb_drained", 64'(exp_q.size() + exp3_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ksa_fsm.md
Name: ksa_fsm

Overview:
- RC4 key-scheduling stage. Sits directly upstream of the decrypt/PRGA stage on the shared 256x8 single-port S RAM.
- On `start`, fills S[i]=i for i=0..255.
- Then runs the KSA swap loop with the 24-bit secret key: j = j + S[i] + key[i mod 3], swap S[i], S[j].
- Asserts `done` when S is a keyed permutation; that signal is the start for the decrypt stage.

Parameters:
- RD_LAT, 2, S RAM read latency in cycles from address presentation to valid q (wait states inserted per read)
- KEY_BYTES, 3, key length in bytes; secret_key width = 8*KEY_BYTES

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  level; sampled in IDLE to begin a schedule
- secret_key  in  24  key; byte 0 = secret_key[23:16], byte 1 = [15:8], byte 2 = [7:0]; must be stable while busy
- q  in  8  S RAM read data
- address  out  8  S RAM address
- data  out  8  S RAM write data
- wren  out  1  S RAM write enable
- busy  out  1  high from the cycle after start is accepted until done rises
- done  out  1  level; high in DONE state

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low. On any edge with reset=0: state=IDLE; address=0, data=0, wren=0, busy=0, done=0; i=0, j=0. This applies mid-operation too, with no partial write after that edge.
- All outputs are registered.
- State IDLE:
  - wren=0, busy=0.
  - start=1 -> INIT_WR with i=0, j=0, done cleared.
- State INIT_WR:
  - Each cycle drives address=i, data=i, wren=1, then i++.
  - 256 consecutive write cycles (addresses 0..255).
  - After the i=255 write: i wraps to 0 -> RD_I.
- State RD_I: address=i, wren=0.
- State WAIT_I: RD_LAT cycles; an internal counter holds the count.
- State CALC_J:
  - si <= q.
  - j <= j + q + key[i mod 3], 8-bit modulo-256 wrap.
  - The key index is a 2-bit mod-3 counter advanced with i, not a divider.
- State RD_J: address=j.
- State WAIT_J: RD_LAT cycles.
- State WR_J: sj <= q; address=j, data=si, wren=1.
- State WR_I: address=i, data=sj, wren=1.
- Loop control after WR_I:
  - i==255 -> DONE.
  - Otherwise i++ -> RD_I.
- Iteration length: 5 + 2*RD_LAT cycles (9 at default).
- Case i==j: the RAM sequence is unchanged. S[i] is read twice and both writes store the same value. No special-casing.
- State DONE:
  - wren=0, busy=0, done=1, address=0.
  - Stays in DONE while start=1.
  - start=0 -> IDLE (done drops on the same edge).
  - New start while in DONE is ignored until start has been seen low.
- start while busy: ignored. secret_key changes while busy: undefined result, no error.
- Latency: done rises 1 + 256 + 256*(5+2*RD_LAT) cycles after the edge on which IDLE samples start=1. That is 2561 cycles at RD_LAT=2.
- Write count per run: exactly 256 + 512 wren cycles.
- Bus rule: wren is never high in IDLE, RD_*, WAIT_*, CALC_J or DONE.

Test Plan:
1. Reset, start=1 with key=0x000000 -> 256 init writes, address=data=0..255 on consecutive cycles. Final RAM contents match the software RC4 KSA model for key {00,00,00}. done rises at cycle 2561.
2. key=0x000249 -> final RAM equals the model. RAM holds a permutation: each value 0..255 appears exactly once. Exactly 768 wren cycles counted.
3. Force the i==j case. The init write at address 0 stores 0 and key byte0=0x00, so j=0 at i=0. -> S[0] unchanged after iteration 0, and two writes to address 0 with identical data.
4. Deassert reset at init i=100, and again during KSA iteration 40 in WR_J. -> Next cycle: wren=0, busy=0, done=0, address=0. A new start produces full correct results.
5. Pulse start again while busy (cycle 500), and hold start=1 in DONE. -> No restart and no extra writes. done remains 1 until start=0. Then IDLE, and a new start reruns the schedule.
6. RD_LAT=3 build with the RAM model delayed 3 cycles -> correct final S. done at cycle 1 + 256 + 256*11 = 3073.
